snn_delay_layer: RTL and testbench

- Parametrised successor to the fixed 2-output spiking core: one fully connected layer of leaky integrate-and-fire (LIF) neurons.
- Every synapse has a programmable weight and a programmable axonal delay in time-steps.
- Neuron state advances only on a `step` strobe. Configuration arrives over a simple register write/read port, which the chip-level SPI slave drives.
- Sits between the SPI config block and the output pins; `out_spikes` and debug data go to `uio_out`/`uo_out`.

---
 rtl/snn_delay_layer.sv | 189 ++++++++++++++++++
 tb/tb_snn_delay_layer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_delay_layer.sv
// snn_delay_layer: fully connected LIF layer, per-synapse weight and axonal delay.
// Optional SNN_REFRACTORY_EN: one-step refractory period after every output spike.
`timescale 1ns/1ps
module snn_delay_layer #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int WBITS = 4,
    parameter int DBITS = 2,
    parameter int VBITS = 8,
    parameter logic signed [VBITS-1:0] THRESH_RST = 8'sd16,
    localparam int SELW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    output logic [7:0]       cfg_rdata,
    input  logic             step,
    input  logic [N_IN-1:0]  in_spikes,
    output logic [N_OUT-1:0] out_spikes,
    output logic             step_done,
    input  logic [SELW-1:0]  dbg_sel,
    output logic [VBITS-1:0] dbg_vmem
);

    localparam int DEPTH = 1 << DBITS;
    localparam int EW    = VBITS + $clog2(N_IN) + 1;
    localparam logic signed [EW-1:0] VMAX = EW'((1 << (VBITS - 1)) - 1);
    localparam logic signed [EW-1:0] VMIN = -VMAX - EW'(1);

    logic signed [WBITS-1:0] weight_q [N_OUT][N_IN];
    logic [DBITS-1:0]        delay_q  [N_OUT][N_IN];
    logic signed [VBITS-1:0] thresh_q;
    logic [2:0]              leak_q;
    logic [7:0]              cnt_q;
    // Past spikes only; the current step's spike is tap 0.
    logic [DEPTH-2:0]        hist_q   [N_IN];
    logic signed [VBITS-1:0] vmem_q   [N_OUT];
    logic [N_OUT-1:0]        spike_q;
    logic                    done_q;
`ifdef SNN_REFRACTORY_EN
    logic [N_OUT-1:0]        refr_q;
`endif

    logic [DEPTH-1:0]        tap    [N_IN];
    logic signed [EW-1:0]    leak_v [N_OUT];
    logic signed [EW-1:0]    sum_v  [N_OUT];
    logic signed [EW-1:0]    vn_v   [N_OUT];
    logic signed [VBITS-1:0] vsat   [N_OUT];
    logic [N_OUT-1:0]        fire;
    logic [7:0]              pop;

    // Delay-line view: index d is the spike that arrived d steps ago.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            tap[i] = {hist_q[i], in_spikes[i]};
        end
    end

    // Per-neuron leak, weighted sum, saturation and threshold.
    always_comb begin
        pop = '0;
        for (int j = 0; j < N_OUT; j++) begin
            leak_v[j] = '0;
            sum_v[j]  = '0;
            if (leak_q != 3'd0) begin
                leak_v[j] = EW'(vmem_q[j] >>> leak_q);
            end
            for (int i = 0; i < N_IN; i++) begin
                if (tap[i][delay_q[j][i]]) begin
                    sum_v[j] = sum_v[j] + EW'(weight_q[j][i]);
                end
            end
`ifdef SNN_REFRACTORY_EN
            if (refr_q[j]) begin
                sum_v[j] = '0;
            end
`endif
            vn_v[j] = EW'(vmem_q[j]) - leak_v[j] + sum_v[j];
            if (vn_v[j] > VMAX) begin
                vsat[j] = VMAX[VBITS-1:0];
            end else if (vn_v[j] < VMIN) begin
                vsat[j] = VMIN[VBITS-1:0];
            end else begin
                vsat[j] = vn_v[j][VBITS-1:0];
            end
            fire[j] = (vsat[j] >= thresh_q);
            pop     = pop + 8'(fire[j]);
        end
    end

    // Configuration registers; a write lands on the same edge a step uses the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                for (int i = 0; i < N_IN; i++) begin
                    weight_q[j][i] <= '0;
                    delay_q[j][i]  <= '0;
                end
            end
            thresh_q <= THRESH_RST;
            leak_q   <= '0;
        end else if (cfg_we) begin
            for (int j = 0; j < N_OUT; j++) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (cfg_addr == 8'(j * N_IN + i)) begin
                        weight_q[j][i] <= cfg_wdata[WBITS-1:0];
                        delay_q[j][i]  <= cfg_wdata[WBITS+DBITS-1:WBITS];
                    end
                end
            end
            if (cfg_addr == 8'hF0) begin
                thresh_q <= VBITS'($signed(cfg_wdata));
            end
            if (cfg_addr == 8'hF1) begin
                leak_q <= cfg_wdata[2:0];
            end
        end
    end

    // Neuron state, delay lines and spike counter advance on step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                hist_q[i] <= '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                vmem_q[j] <= '0;
            end
            spike_q <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SNN_REFRACTORY_EN
            refr_q  <= '0;
`endif
        end else begin
            done_q <= step;
            if (step) begin
                for (int i = 0; i < N_IN; i++) begin
                    hist_q[i] <= tap[i][DEPTH-2:0];
                end
                for (int j = 0; j < N_OUT; j++) begin
                    vmem_q[j] <= fire[j] ? '0 : vsat[j];
                end
                spike_q <= fire;
                cnt_q   <= cnt_q + pop;
`ifdef SNN_REFRACTORY_EN
                refr_q  <= fire;
`endif
            end
        end
    end

    // Combinational register read-back; unmapped addresses read as zero.
    always_comb begin
        cfg_rdata = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (cfg_addr == 8'(j * N_IN + i)) begin
                    cfg_rdata = 8'({delay_q[j][i], weight_q[j][i]});
                end
            end
        end
        if (cfg_addr == 8'hF0) begin
            cfg_rdata = 8'(thresh_q);
        end
        if (cfg_addr == 8'hF1) begin
            cfg_rdata = {5'b0, leak_q};
        end
        if (cfg_addr == 8'hF2) begin
            cfg_rdata = cnt_q;
        end
    end

    // Debug membrane mux.
    always_comb begin
        dbg_vmem = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (dbg_sel == SELW'(j)) begin
                dbg_vmem = vmem_q[j];
            end
        end
    end

    assign out_spikes = spike_q;
    assign step_done  = done_q;

endmodule

// File: tb/tb_snn_delay_layer.sv
// tb_snn_delay_layer: scoreboard bench for snn_delay_layer.
// A behavioural model predicts spikes and membranes per step.
`timescale 1ns/1ps
module tb_snn_delay_layer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic [7:0] cfg_rdata;
    logic       step = 1'b0;
    logic [3:0] in_spikes = '0;
    logic [1:0] out_spikes;
    logic       step_done;
    logic [0:0] dbg_sel = '0;
    logic [7:0] dbg_vmem;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0] sp;
        logic [7:0] v1;
        logic [7:0] v0;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int mw [2][4];
    int md [2][4];
    int mthr, mls, mcnt;
    bit mh [4][4];
    int mv [2];
    bit mref [2];

    always #5 clk = ~clk;

    snn_delay_layer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .step       (step),
        .in_spikes  (in_spikes),
        .out_spikes (out_spikes),
        .step_done  (step_done),
        .dbg_sel    (dbg_sel),
        .dbg_vmem   (dbg_vmem)
    );

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 4; i++) begin
                mw[j][i] = 0;
                md[j][i] = 0;
            end
            mv[j] = 0;
            mref[j] = 1'b0;
        end
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) mh[i][k] = 1'b0;
        mthr = 16;
        mls = 0;
        mcnt = 0;
    endfunction

    function automatic void model_cfg(input logic [7:0] a, input logic [7:0] d);
        logic signed [3:0] w4;
        logic signed [7:0] t8;
        w4 = d[3:0];
        t8 = d;
        if (a < 8) begin
            mw[a / 4][a % 4] = w4;
            md[a / 4][a % 4] = int'(d[5:4]);
        end else if (a == 8'hF0) begin
            mthr = t8;
        end else if (a == 8'hF1) begin
            mls = int'(d[2:0]);
        end
    endfunction

    function automatic void model_step(input logic [3:0] sp);
        logic [1:0] s;
        int lk, sm, vn;
        for (int i = 0; i < 4; i++) begin
            for (int k = 3; k > 0; k--) mh[i][k] = mh[i][k-1];
            mh[i][0] = sp[i];
        end
        for (int j = 0; j < 2; j++) begin
            lk = (mls == 0) ? 0 : (mv[j] >>> mls);
            sm = 0;
            for (int i = 0; i < 4; i++)
                if (mh[i][md[j][i]]) sm += mw[j][i];
`ifdef SNN_REFRACTORY_EN
            if (mref[j]) sm = 0;
`endif
            vn = mv[j] - lk + sm;
            if (vn > 127) vn = 127;
            if (vn < -128) vn = -128;
            s[j] = (vn >= mthr);
            mv[j] = s[j] ? 0 : vn;
            mref[j] = s[j];
        end
        mcnt = (mcnt + int'(s[0]) + int'(s[1])) % 256;
        exp_q.push_back('{sp: s, v1: 8'(mv[1]), v0: 8'(mv[0])});
    endfunction

    // Scoreboard: every step_done pops one prediction.
    always @(negedge clk) begin
        if (step_done) begin
            check("sb_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_spikes", out_spikes, e.sp);
                check("sb_vmem", $signed(dbg_vmem),
                      dbg_sel[0] ? $signed(e.v1) : $signed(e.v0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_wr(input logic [7:0] a, input logic [7:0] d);
        model_cfg(a, d);
        tick();
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] x);
        cfg_addr = a;
        #1;
        check(tag, cfg_rdata, x);
    endtask

    task automatic do_step(input logic [3:0] sp);
        model_step(sp);
        tick();
        step = 1'b1;
        in_spikes = sp;
        tick();
        step = 1'b0;
        in_spikes = '0;
    endtask

    task automatic step_cfg(input logic [3:0] sp, input logic [7:0] a,
                            input logic [7:0] d);
        model_step(sp);
        model_cfg(a, d);
        tick();
        step = 1'b1;
        in_spikes = sp;
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick();
        step = 1'b0;
        in_spikes = '0;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        check("q_empty", exp_q.size(), 0);
        rst_n = 1'b0;
        model_reset();
        tick();
        step = 1'b1;
        in_spikes = 4'hF;
        tick();
        step = 1'b0;
        in_spikes = '0;
        check("rst_no_done", step_done, 0);
        check("rst_spikes", out_spikes, 0);
        rst_n = 1'b1;
        tick();
    endtask

    int seq [5] = '{8, 4, 2, 1, 1};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("rst_out", out_spikes, 0);
        check("rst_done", step_done, 0);
        check("rst_vmem0", $signed(dbg_vmem), 0);
        dbg_sel = 1'b1;
        #1;
        check("rst_vmem1", $signed(dbg_vmem), 0);
        dbg_sel = 1'b0;
        rd("rst_thr", 8'hF0, 8'd16);
        rd("rst_leak", 8'hF1, 8'd0);
        rd("rst_cnt", 8'hF2, 8'd0);
        for (int a = 0; a < 8; a++) rd("rst_syn", 8'(a), 8'd0);
        rst_n = 1'b1;

        // Two +4 synapses give +8 per step on neuron 0.
        cfg_wr(8'd0, 8'h04);
        cfg_wr(8'd1, 8'h04);
        rd("a_rd0", 8'd0, 8'h04);
        do_step(4'b0011);
        check("a_v1", $signed(dbg_vmem), 8);
        check("a_s1", out_spikes, 0);
        check("a_done", step_done, 1);
        tick();
        check("a_done_fall", step_done, 0);
        do_step(4'b0011);
        check("a_s2", out_spikes, 2'b01);
        check("a_v2", $signed(dbg_vmem), 0);
        rd("a_cnt", 8'hF2, 8'd1);
        cfg_wr(8'hF2, 8'h55);
        rd("a_ro", 8'hF2, 8'd1);
        cfg_wr(8'h40, 8'hFF);
        rd("a_unmap", 8'h40, 8'd0);

        // Delay 3 on synapse 1->1.
        do_reset();
        dbg_sel = 1'b1;
        cfg_wr(8'd5, 8'h37);
        cfg_wr(8'hF0, 8'h05);
        rd("b_rd5", 8'd5, 8'h37);
        rd("b_thr", 8'hF0, 8'h05);
        do_step(4'b0010);
        check("b_k0", out_spikes, 0);
        do_step(4'b0000);
        do_step(4'b0000);
        check("b_k2", out_spikes, 0);
        do_step(4'b0000);
        check("b_k3", out_spikes, 2'b10);
        dbg_sel = 1'b0;

        // Negative saturation.
        do_reset();
        for (int a = 0; a < 4; a++) cfg_wr(8'(a), 8'h08);
        cfg_wr(8'hF0, 8'h7F);
        repeat (40) do_step(4'b1111);
        check("c_sat", $signed(dbg_vmem), -128);
        check("c_nospk", out_spikes, 0);

        // Leak decay from 16.
        do_reset();
        cfg_wr(8'd0, 8'h04);
        cfg_wr(8'd1, 8'h04);
        cfg_wr(8'hF0, 8'h7F);
        do_step(4'b0011);
        do_step(4'b0011);
        check("d_pre", $signed(dbg_vmem), 16);
        cfg_wr(8'hF1, 8'h01);
        rd("d_leak", 8'hF1, 8'h01);
        for (int k = 0; k < 5; k++) begin
            do_step(4'b0000);
            check("d_seq", $signed(dbg_vmem), seq[k]);
        end

        // Weight write coincident with step.
        do_reset();
        cfg_wr(8'd0, 8'h03);
        cfg_wr(8'hF0, 8'h7F);
        step_cfg(4'b0001, 8'd0, 8'h05);
        check("e_old", $signed(dbg_vmem), 3);
        do_step(4'b0001);
        check("e_new", $signed(dbg_vmem), 8);
        rd("e_rd0", 8'd0, 8'h05);

        // Back-to-back steps at threshold.
        do_reset();
        cfg_wr(8'd0, 8'h05);
        cfg_wr(8'hF0, 8'h05);
        model_step(4'b0001);
        model_step(4'b0001);
        model_step(4'b0001);
        tick();
        step = 1'b1;
        in_spikes = 4'b0001;
        repeat (3) tick();
        step = 1'b0;
        in_spikes = '0;
        tick();
`ifdef SNN_REFRACTORY_EN
        rd("f_cnt", 8'hF2, 8'd2);
`else
        rd("f_cnt", 8'hF2, 8'd3);
`endif

        repeat (2) tick();
        check("q_final", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
